vec_reg_file: RTL and testbench
===============================

Name: vec_reg_file

Overview:
- Parametrised vector register file for the SIMD datapath: NUM_REGS registers, each LANES x WIDTH bits.
- Fed by the load/store path (masked host write port) and the ALU writeback port. Read by the host read port; two fixed source registers are exported to the ALU.
- Single-edge, fully synchronous to clk, with async reset.
- Adds lane write masks, per-register valid tracking, a read handshake, and a sticky write-drop status.

Parameters:
- LANES, 16, lanes per register.
- WIDTH, 32, bits per lane.
- NUM_REGS, 4, register count (>=4, power of 2).
- SRC_A, 0, register index exported on opa_out.
- SRC_B, 1, register index exported on opb_out.
- DST_A, 2, ALU writeback destination for alu_data1.
- DST_B, 3, ALU writeback destination for alu_data2 (must differ from DST_A).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  host write strobe.
- wr_sel  in  SEL_W=$clog2(NUM_REGS)  host write register index.
- wr_mask  in  LANES  per-lane write enable (1 = write lane).
- wr_data  in  WIDTH x [0:LANES-1]  host write data.
- alu_we  in  1  ALU writeback strobe.
- alu_data1  in  WIDTH x [0:LANES-1]  result to DST_A.
- alu_data2  in  WIDTH x [0:LANES-1]  result to DST_B.
- rd_req  in  1  read request.
- rd_sel  in  SEL_W  read register index.
- rd_data  out  WIDTH x [0:LANES-1]  read data, registered.
- rd_valid  out  1  one-cycle pulse, rd_data valid.
- rd_err  out  1  with rd_valid: register read had never been written.
- opa_out  out  WIDTH x [0:LANES-1]  continuous view of reg SRC_A.
- opb_out  out  WIDTH x [0:LANES-1]  continuous view of reg SRC_B.
- reg_valid  out  NUM_REGS  bit i = register i written since reset.
- wr_drop  out  1  sticky: a host write was discarded.

Behaviour:
- Reset (async assert, sync release):
  - all register contents 0, reg_valid=0.
  - rd_data=0, rd_valid=0, rd_err=0, wr_drop=0.
- Write priority:
  - alu_we=1: DST_A<=alu_data1 and DST_B<=alu_data2, all lanes, mask ignored; sets reg_valid[DST_A], reg_valid[DST_B].
  - Otherwise wr_en=1: lanes of wr_sel with wr_mask[i]=1 take wr_data[i]; other lanes hold. reg_valid[wr_sel] is set only if wr_mask!=0.
  - wr_en with wr_mask=0 is a no-op and does not count as a drop.
- Write drop: alu_we and wr_en in the same cycle discards the host write and sets wr_drop, even if wr_sel is not a destination. wr_drop clears only on rst.
- Read: rd_req sampled at edge N gives rd_valid=1 after edge N with rd_data = reg[rd_sel].
  - Fully pipelined: back-to-back requests return every cycle; no backpressure.
  - rd_valid=0 when no request; rd_data holds its last value.
- rd_err = !reg_valid[rd_sel] at sample time. Data is then the reset zeros.
- Read/write same cycle, same register (without bypass): read returns the pre-write contents (read-before-write).
- Reads and writes are independent: a read never blocks or delays a write.
- opa_out/opb_out are combinational from register state and reflect a write from the next cycle on.
- Reset asserted mid-stream: a pending rd_valid is killed, and no read response follows reset release.

Optional Feature:
- Macro: VRF_BYPASS_EN.
- Defined: a read coinciding with a write to the same register returns the post-write value per lane: masked lanes take new data, ALU writes forward the full vector. rd_err evaluates the post-write valid bit.
- Undefined: read-before-write as above. No forwarding muxes are built.

Decomposition:
- Package vrf_pkg:
  - default constants LANES_D, WIDTH_D, NUM_REGS_D;
  - typedef lane_t (logic [WIDTH-1:0]);
  - typedef vec_t (lane_t [0:LANES-1]);
  - sel_t width function.
- One natural sub-module, vrf_lane_merge: per-lane masked merge of old and new vector. It is used by the write path and, with bypass, by the read path.

Test Plan:
- Reset, then rd_req rd_sel=2: rd_valid=1 one cycle later, rd_data all 0, rd_err=1, reg_valid=4'b0000.
- wr_en sel=1, wr_mask=16'h00FF, all lanes 32'hA5A5_0001: lanes 0-7 read back A5A5_0001 and lanes 8-15 read 0. reg_valid[1]=1; opb_out matches the next cycle.
- alu_we with alu_data1 lanes=32'h1111_1111 and alu_data2 lanes=32'h2222_2222, plus wr_en sel=0 in the same cycle: regs 2/3 updated, reg0 unchanged, wr_drop=1 and stays 1.
- rd_req on 4 consecutive cycles, sel=0,1,2,3: 4 consecutive rd_valid pulses with matching data in order.
- Same-cycle wr_en sel=1 data 32'hDEAD_BEEF full mask, and rd_req sel=1 holding 32'hA5A5_0001:
  - without VRF_BYPASS_EN, rd_data=A5A5_0001;
  - with it, rd_data=DEAD_BEEF.
- rst pulsed asynchronously one cycle after rd_req: rd_valid never asserts, and all state reads back as the reset values.

Source files
------------

// File: rtl/vrf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vrf_pkg
//  Description : Shared constants, lane/vector types and the select-width
//                helper for the SIMD vector register file.
//  Revision    : 1.0  initial release
// ============================================================================
package vrf_pkg;

  localparam int LANES_D    = 16;
  localparam int WIDTH_D    = 32;
  localparam int NUM_REGS_D = 4;

  typedef logic [WIDTH_D-1:0] lane_t;
  typedef lane_t [0:LANES_D-1] vec_t;

  // Register-select width; never narrower than one bit
  function automatic int sel_w(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vec_reg_file_if.sv
`default_nettype none
// ============================================================================
//  Module      : vec_reg_file_if
//  Description : Host write, ALU writeback, read and status bundle of the
//                vector register file. slave = register file side,
//                master = host/ALU side.
//  Revision    : 1.0  initial release
// ============================================================================
interface vec_reg_file_if
  import vrf_pkg::*;
#(
  parameter int LANES    = LANES_D,
  parameter int WIDTH    = WIDTH_D,
  parameter int NUM_REGS = NUM_REGS_D
) ();

  localparam int SEL_W = sel_w(NUM_REGS);

  // Host write port
  logic                              wr_en;
  logic [SEL_W-1:0]                  wr_sel;
  logic [LANES-1:0]                  wr_mask;
  logic [0:LANES-1][WIDTH-1:0]       wr_data;

  // ALU writeback port
  logic                              alu_we;
  logic [0:LANES-1][WIDTH-1:0]       alu_data1;
  logic [0:LANES-1][WIDTH-1:0]       alu_data2;

  // Host read port
  logic                              rd_req;
  logic [SEL_W-1:0]                  rd_sel;
  logic [0:LANES-1][WIDTH-1:0]       rd_data;
  logic                              rd_valid;
  logic                              rd_err;

  // Operand export and status
  logic [0:LANES-1][WIDTH-1:0]       opa_out;
  logic [0:LANES-1][WIDTH-1:0]       opb_out;
  logic [NUM_REGS-1:0]               reg_valid;
  logic                              wr_drop;

  modport slave (
    input  wr_en, wr_sel, wr_mask, wr_data,
    input  alu_we, alu_data1, alu_data2,
    input  rd_req, rd_sel,
    output rd_data, rd_valid, rd_err,
    output opa_out, opb_out, reg_valid, wr_drop
  );

  modport master (
    output wr_en, wr_sel, wr_mask, wr_data,
    output alu_we, alu_data1, alu_data2,
    output rd_req, rd_sel,
    input  rd_data, rd_valid, rd_err,
    input  opa_out, opb_out, reg_valid, wr_drop
  );

endinterface
`default_nettype wire

// File: rtl/vrf_lane_merge.sv
`default_nettype none
// ============================================================================
//  Module      : vrf_lane_merge
//  Description : Per-lane masked merge: lane l takes i_new[l] when i_mask[l]
//                is set, otherwise keeps i_old[l]. Purely combinational.
//  Revision    : 1.0  initial release
// ============================================================================
module vrf_lane_merge #(
  parameter int LANES = 16,
  parameter int WIDTH = 32
) (
  input  logic [0:LANES-1][WIDTH-1:0] i_old,
  input  logic [0:LANES-1][WIDTH-1:0] i_new,
  input  logic [LANES-1:0]            i_mask,
  output logic [0:LANES-1][WIDTH-1:0] o_merged
);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign o_merged[l] = i_mask[l] ? i_new[l] : i_old[l];
  end

endmodule
`default_nettype wire

// File: rtl/vec_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : vec_reg_file
//  Description : NUM_REGS x (LANES x WIDTH) vector register file. ALU
//                writeback has priority over the masked host write port; a
//                colliding host write is dropped and flagged in the sticky
//                wr_drop bit. Registered, fully pipelined read port with a
//                never-written error flag. SRC_A/SRC_B exported continuously.
//  Options     : VRF_BYPASS_EN - forward same-cycle write data to the read
//                port (default: read-before-write, no forwarding logic).
//  Revision    : 1.0  initial release
// ============================================================================
module vec_reg_file
  import vrf_pkg::*;
#(
  parameter int LANES    = LANES_D,
  parameter int WIDTH    = WIDTH_D,
  parameter int NUM_REGS = NUM_REGS_D,
  parameter int SRC_A    = 0,
  parameter int SRC_B    = 1,
  parameter int DST_A    = 2,
  parameter int DST_B    = 3
) (
  input  logic          clk,
  input  logic          rst,
  vec_reg_file_if.slave bus
);

  localparam int SEL_W = sel_w(NUM_REGS);

  typedef logic [0:LANES-1][WIDTH-1:0] pvec_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  pvec_t               r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_valid;
  pvec_t               r_rd_data;
  logic                r_rd_valid;
  logic                r_rd_err;
  logic                r_wr_drop;

  // --------------------------------------------------------------------------
  // Write path
  // --------------------------------------------------------------------------
  logic                w_host_any;   // host write touches at least one lane
  logic                w_host_wr;    // host write actually commits
  logic                w_drop;       // host write lost to ALU writeback
  pvec_t               w_wr_old;
  pvec_t               w_wr_merged;
  logic [NUM_REGS-1:0] w_valid_nxt;

  assign w_host_any = |bus.wr_mask;
  assign w_host_wr  = bus.wr_en & w_host_any & ~bus.alu_we;
  assign w_drop     = bus.wr_en & w_host_any &  bus.alu_we;
  assign w_wr_old   = r_regs[bus.wr_sel];

  vrf_lane_merge #(
    .LANES (LANES),
    .WIDTH (WIDTH)
  ) u_wr_merge (
    .i_old    (w_wr_old),
    .i_new    (bus.wr_data),
    .i_mask   (bus.wr_mask),
    .o_merged (w_wr_merged)
  );

  // Valid bits after this cycle's write (ALU marks both destinations)
  always_comb begin
    w_valid_nxt = r_valid;
    if (bus.alu_we) begin
      w_valid_nxt[DST_A] = 1'b1;
      w_valid_nxt[DST_B] = 1'b1;
    end else if (w_host_wr) begin
      w_valid_nxt[bus.wr_sel] = 1'b1;
    end
  end

  // Register contents and valid tracking; ALU writeback wins over host writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_valid <= '0;
    end else begin
      if (bus.alu_we) begin
        r_regs[DST_A] <= bus.alu_data1;
        r_regs[DST_B] <= bus.alu_data2;
      end else if (w_host_wr) begin
        r_regs[bus.wr_sel] <= w_wr_merged;
      end
      r_valid <= w_valid_nxt;
    end
  end

  // Sticky drop flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_drop <= 1'b0;
    end else if (w_drop) begin
      r_wr_drop <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Read path
  // --------------------------------------------------------------------------
  pvec_t w_rd_vec;
  logic  w_rd_err;

`ifdef VRF_BYPASS_EN
  localparam logic [SEL_W-1:0] c_dst_a = SEL_W'(DST_A);
  localparam logic [SEL_W-1:0] c_dst_b = SEL_W'(DST_B);

  pvec_t            w_rd_base;
  logic [LANES-1:0] w_rd_fwd_mask;

  // Pick the forwarding source: ALU replaces the whole vector, a host write
  // forwards only its masked lanes on top of the stored contents
  always_comb begin
    w_rd_base     = r_regs[bus.rd_sel];
    w_rd_fwd_mask = '0;
    if (bus.alu_we) begin
      if (bus.rd_sel == c_dst_a) begin
        w_rd_base = bus.alu_data1;
      end else if (bus.rd_sel == c_dst_b) begin
        w_rd_base = bus.alu_data2;
      end
    end else if (w_host_wr && (bus.wr_sel == bus.rd_sel)) begin
      w_rd_fwd_mask = bus.wr_mask;
    end
  end

  vrf_lane_merge #(
    .LANES (LANES),
    .WIDTH (WIDTH)
  ) u_rd_merge (
    .i_old    (w_rd_base),
    .i_new    (bus.wr_data),
    .i_mask   (w_rd_fwd_mask),
    .o_merged (w_rd_vec)
  );

  assign w_rd_err = ~w_valid_nxt[bus.rd_sel];
`else
  // Read-before-write: the stored contents are returned as they stand
  assign w_rd_vec = r_regs[bus.rd_sel];
  assign w_rd_err = ~r_valid[bus.rd_sel];
`endif

  // One-cycle read response; data holds between requests
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= bus.rd_req;
      if (bus.rd_req) begin
        r_rd_data <= w_rd_vec;
        r_rd_err  <= w_rd_err;
      end else begin
        r_rd_err  <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.rd_data   = r_rd_data;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_err    = r_rd_err;
  assign bus.opa_out   = r_regs[SRC_A];
  assign bus.opb_out   = r_regs[SRC_B];
  assign bus.reg_valid = r_valid;
  assign bus.wr_drop   = r_wr_drop;

endmodule
`default_nettype wire

// File: tb/tb_vec_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vec_reg_file
//  Description : Self-checking bench for vec_reg_file: directed scenarios,
//                randomized traffic against a lane-level reference model, and
//                asynchronous reset during an outstanding read.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vec_reg_file;
  import vrf_pkg::*;

  localparam int NR = NUM_REGS_D;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  vec_reg_file_if #(.LANES(LANES_D), .WIDTH(WIDTH_D), .NUM_REGS(NR)) vif ();

  vec_reg_file #(
    .LANES    (LANES_D),
    .WIDTH    (WIDTH_D),
    .NUM_REGS (NR),
    .SRC_A    (0),
    .SRC_B    (1),
    .DST_A    (2),
    .DST_B    (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  // Reference model state
  vec_t          m_regs [NR];
  logic [NR-1:0] m_valid;
  logic          m_drop;
  vec_t          m_last;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) m_regs[r] = '0;
    m_valid = '0;
    m_drop  = 1'b0;
    m_last  = '0;
  endtask

  task automatic idle();
    vif.wr_en     = 1'b0;
    vif.wr_sel    = '0;
    vif.wr_mask   = '0;
    vif.wr_data   = '0;
    vif.alu_we    = 1'b0;
    vif.alu_data1 = '0;
    vif.alu_data2 = '0;
    vif.rd_req    = 1'b0;
    vif.rd_sel    = '0;
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, ".reg_valid"}, 512'(vif.reg_valid), 512'(m_valid));
    check_eq({tag, ".wr_drop"},   512'(vif.wr_drop),   512'(m_drop));
    check_eq({tag, ".opa"},       512'(vif.opa_out),   512'(m_regs[0]));
    check_eq({tag, ".opb"},       512'(vif.opb_out),   512'(m_regs[1]));
  endtask

  // Apply the current inputs for one clock edge in the model, then check
  task automatic tick(input string tag);
    vec_t          nregs [NR];
    logic [NR-1:0] nvalid;
    logic          ndrop;
    logic          exp_v;
    logic          exp_err;
    vec_t          exp_rd;
    int            ws;
    int            rs;
    ws     = int'(vif.wr_sel);
    rs     = int'(vif.rd_sel);
    nregs  = m_regs;
    nvalid = m_valid;
    ndrop  = m_drop;
    if (vif.alu_we) begin
      nregs[2]  = vif.alu_data1;
      nregs[3]  = vif.alu_data2;
      nvalid[2] = 1'b1;
      nvalid[3] = 1'b1;
      if (vif.wr_en && vif.wr_mask != 0) ndrop = 1'b1;
    end else if (vif.wr_en && vif.wr_mask != 0) begin
      for (int l = 0; l < LANES_D; l++)
        if (vif.wr_mask[l]) nregs[ws][l] = vif.wr_data[l];
      nvalid[ws] = 1'b1;
    end
    exp_v = vif.rd_req;
`ifdef VRF_BYPASS_EN
    exp_rd  = nregs[rs];
    exp_err = !nvalid[rs];
`else
    exp_rd  = m_regs[rs];
    exp_err = !m_valid[rs];
`endif
    @(posedge clk);
    #1;
    m_regs  = nregs;
    m_valid = nvalid;
    m_drop  = ndrop;
    if (exp_v) m_last = exp_rd;
    check_eq({tag, ".rd_valid"}, 512'(vif.rd_valid), 512'(exp_v));
    check_eq({tag, ".rd_data"},  512'(vif.rd_data),  512'(m_last));
    if (exp_v) check_eq({tag, ".rd_err"}, 512'(vif.rd_err), 512'(exp_err));
    check_state(tag);
  endtask

  initial begin
    logic [31:0] lane0;
    idle();
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // Reset state
    check_eq("reset.rd_valid", 512'(vif.rd_valid), 512'(0));
    check_eq("reset.rd_data",  512'(vif.rd_data),  512'(0));
    check_eq("reset.rd_err",   512'(vif.rd_err),   512'(0));
    check_state("reset");
    @(posedge clk); #1;

    // Read of a never-written register
    vif.rd_req = 1'b1; vif.rd_sel = 2;
    tick("rd_unwritten");
    check_eq("rd_unwritten.err_const", 512'(vif.rd_err), 512'(1));
    idle();

    // Masked host write to reg 1, then read back
    vif.wr_en = 1'b1; vif.wr_sel = 1; vif.wr_mask = 16'h00FF;
    vif.wr_data = {LANES_D{32'hA5A5_0001}};
    tick("wr_mask");
    idle();
    vif.rd_req = 1'b1; vif.rd_sel = 1;
    tick("rd_mask");
    check_eq("rd_mask.lane0", 512'(vif.rd_data[0]), 512'(32'hA5A5_0001));
    check_eq("rd_mask.lane8", 512'(vif.rd_data[8]), 512'(0));
    idle();

    // Masked write with empty mask: no-op, no drop
    vif.wr_en = 1'b1; vif.wr_sel = 0; vif.wr_mask = '0;
    vif.wr_data = {LANES_D{32'hFFFF_FFFF}};
    tick("wr_nomask");
    idle();

    // ALU writeback colliding with a host write
    vif.alu_we = 1'b1;
    vif.alu_data1 = {LANES_D{32'h1111_1111}};
    vif.alu_data2 = {LANES_D{32'h2222_2222}};
    vif.wr_en = 1'b1; vif.wr_sel = 0; vif.wr_mask = 16'hFFFF;
    vif.wr_data = {LANES_D{32'h3333_3333}};
    tick("alu_drop");
    check_eq("alu_drop.flag", 512'(vif.wr_drop), 512'(1));
    idle();
    tick("drop_sticky");

    // Back-to-back reads of every register
    for (int r = 0; r < NR; r++) begin
      vif.rd_req = 1'b1; vif.rd_sel = 2'(r);
      tick("rd_b2b");
    end
    idle();

    // Same-cycle write and read of reg 1
    vif.wr_en = 1'b1; vif.wr_sel = 1; vif.wr_mask = 16'hFFFF;
    vif.wr_data = {LANES_D{32'hDEAD_BEEF}};
    vif.rd_req = 1'b1; vif.rd_sel = 1;
    tick("rw_same");
    lane0 = vif.rd_data[0];
`ifdef VRF_BYPASS_EN
    check_eq("rw_same.lane0", 512'(lane0), 512'(32'hDEAD_BEEF));
`else
    check_eq("rw_same.lane0", 512'(lane0), 512'(32'hA5A5_0001));
`endif
    idle();

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      vif.rd_req  = 1'($urandom_range(0, 1));
      vif.rd_sel  = 2'($urandom_range(0, NR - 1));
      vif.wr_en   = 1'($urandom_range(0, 1));
      vif.wr_sel  = 2'($urandom_range(0, NR - 1));
      vif.wr_mask = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      vif.alu_we  = ($urandom_range(0, 7) == 0);
      for (int l = 0; l < LANES_D; l++) begin
        vif.wr_data[l]   = $urandom;
        vif.alu_data1[l] = $urandom;
        vif.alu_data2[l] = $urandom;
      end
      tick("rand");
    end
    idle();
    @(posedge clk); #1;

    // Reset while a read response is pending
    vif.rd_req = 1'b1; vif.rd_sel = 3;
    @(posedge clk); #1;
    vif.rd_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_eq("rst_mid.kill", 512'(vif.rd_valid), 512'(0));
    // Request issued while reset is held must not produce a response
    vif.rd_req = 1'b1; vif.rd_sel = 1;
    @(posedge clk); #1;
    vif.rd_req = 1'b0;
    #3 rst = 1'b0;
    for (int c = 0; c < 3; c++) tick("rst_quiet");
    for (int r = 0; r < NR; r++) begin
      vif.rd_req = 1'b1; vif.rd_sel = 2'(r);
      tick("rst_rd");
    end
    idle();
    tick("rst_end");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
